// File: rtl/vend_pkg.sv
// -----------------------------------------------------------------------------
// vend_pkg
// Shared definitions for the vending-machine transaction controller:
//   - FSM state encoding (matches the 2-bit state output)
//   - coin codes and their denomination values
//   - selection error codes
//   - coin_value(): code -> value, 0 for any unknown code
// -----------------------------------------------------------------------------
package vend_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'b00,
      ST_COLLECT  = 2'b01,
      ST_DISPENSE = 2'b10,
      ST_CHANGE   = 2'b11
   } state_e;

   typedef enum logic [1:0] {
      COIN_5  = 2'b00,
      COIN_10 = 2'b01,
      COIN_20 = 2'b10,
      COIN_50 = 2'b11
   } coin_e;

   localparam logic [7:0] VAL_5  = 8'd5;
   localparam logic [7:0] VAL_10 = 8'd10;
   localparam logic [7:0] VAL_20 = 8'd20;
   localparam logic [7:0] VAL_50 = 8'd50;

   typedef enum logic [1:0] {
      SEL_NONE      = 2'b00,
      SEL_NO_STOCK  = 2'b01,
      SEL_NO_CREDIT = 2'b10
   } sel_err_e;

   // A code that matches none of the four denominations (X/Z in simulation)
   // yields 0, which the acceptance logic treats as an invalid coin.
   function automatic logic [7:0] coin_value(input logic [1:0] code);
      logic [7:0] v;
      case (code)
         COIN_5:  v = VAL_5;
         COIN_10: v = VAL_10;
         COIN_20: v = VAL_20;
         COIN_50: v = VAL_50;
         default: v = 8'd0;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/vend_change_picker.sv
// -----------------------------------------------------------------------------
// change_picker
// Combinational greedy change selection: returns the code of the largest
// denomination that does not exceed the given credit.
// Ports:
//   credit_i  in  CREDIT_W  credit to be returned
//   coin_o    out 2         coin code (00=5, 01=10, 10=20, 11=50)
// A credit below 5 yields the 5 code; the caller only uses the result while
// credit is a non-zero multiple of 5.
// -----------------------------------------------------------------------------
module change_picker
   import vend_pkg::*;
#(
   parameter int CREDIT_W = 16
) (
   input  logic [CREDIT_W-1:0] credit_i,
   output logic [1:0]          coin_o
);

   always_comb begin
      coin_o = COIN_5;
      if (credit_i >= CREDIT_W'(VAL_50)) begin
         coin_o = COIN_50;
      end else if (credit_i >= CREDIT_W'(VAL_20)) begin
         coin_o = COIN_20;
      end else if (credit_i >= CREDIT_W'(VAL_10)) begin
         coin_o = COIN_10;
      end
   end

endmodule

// File: rtl/vend_sequencer.sv
// -----------------------------------------------------------------------------
// vend_sequencer
// Vending-machine transaction controller. Owns the customer credit, accepts
// coins, checks a selection against price/stock, hands the product to the
// dispenser (valid/ready) and then pays back change one coin at a time.
// Flow: IDLE -> COLLECT -> DISPENSE -> CHANGE -> IDLE.
//
// Ports (all outputs registered):
//   clock_i, reset_i            clock, asynchronous active-high reset
//   coin_valid_i, coin_i        coin strobe and code (00=5,01=10,10=20,11=50)
//   select_valid_i              selection strobe
//   product_id_i, price_i       selected product and its price
//   stock_ok_i                  selected product is in stock
//   cancel_i                    refund request
//   vend_valid_o, vend_id_o     dispense request / product, vend_ready_i accept
//   did_buy_o                   one-cycle pulse on the dispense handshake
//   change_valid_o, change_coin_o  change coin offer, change_ready_i accept
//   credit_o, state_o           current credit and state
//   coin_reject_o               one-cycle pulse: coin returned unaccepted
//   sel_error_o                 one-cycle: 01 out of stock, 10 low credit
//
// Optional feature, macro VEND_TIMEOUT_EN: an inactivity counter in COLLECT
// refunds all credit after TIMEOUT_CYCLES cycles without any strobe. Without
// the macro COLLECT waits indefinitely.
// -----------------------------------------------------------------------------
module vend_sequencer
   import vend_pkg::*;
#(
   parameter int CREDIT_W       = 16,
   parameter int MAX_CREDIT     = 200,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic                clock_i,
   input  logic                reset_i,
   input  logic                coin_valid_i,
   input  logic [1:0]          coin_i,
   input  logic                select_valid_i,
   input  logic [2:0]          product_id_i,
   input  logic [7:0]          price_i,
   input  logic                stock_ok_i,
   input  logic                cancel_i,
   output logic                vend_valid_o,
   output logic [2:0]          vend_id_o,
   input  logic                vend_ready_i,
   output logic                did_buy_o,
   output logic                change_valid_o,
   output logic [1:0]          change_coin_o,
   input  logic                change_ready_i,
   output logic [CREDIT_W-1:0] credit_o,
   output logic [1:0]          state_o,
   output logic                coin_reject_o,
   output logic [1:0]          sel_error_o
);

   localparam logic [CREDIT_W:0] MAX_C = (CREDIT_W+1)'(MAX_CREDIT);

   state_e              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [2:0]          vend_id_q, vend_id_d;
   logic                vend_valid_q;
   logic                did_buy_q, did_buy_d;
   logic                change_valid_q;
   logic [1:0]          change_coin_q;
   logic                coin_reject_q, coin_reject_d;
   sel_err_e            sel_error_q, sel_error_d;

   logic [CREDIT_W-1:0] coin_val;
   logic [CREDIT_W-1:0] price_ext;
   logic [CREDIT_W-1:0] change_val;
   logic [CREDIT_W:0]   coin_sum;
   logic                coin_ok;
   logic                coin_try;
   logic                tmo_hit;
   logic [1:0]          pick_coin;

   assign coin_val   = CREDIT_W'(coin_value(coin_i));
   assign price_ext  = CREDIT_W'(price_i);
   assign change_val = CREDIT_W'(coin_value(change_coin_q));
   // One extra bit so the overflow test itself cannot wrap.
   assign coin_sum   = {1'b0, credit_q} + {1'b0, coin_val};
   assign coin_ok    = (coin_val != '0) && (coin_sum <= MAX_C);

`ifdef VEND_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             strobe;

   assign strobe = coin_valid_i | select_valid_i | cancel_i;
   // Counter is held at 0 outside COLLECT, so it starts from 0 on entry.
   assign tmo_d   = (state_q == ST_COLLECT && !strobe) ? tmo_q + TMO_W'(1) : '0;
   assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_d;
      end
   end
`else
   // Never fires: COLLECT waits indefinitely.
   assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

   // Next change coin is picked from the next credit so that change_coin_o
   // is registered and already correct on the cycle CHANGE is entered.
   change_picker #(
      .CREDIT_W (CREDIT_W)
   ) u_picker (
      .credit_i (credit_d),
      .coin_o   (pick_coin)
   );

   always_comb begin
      state_d       = state_q;
      credit_d      = credit_q;
      vend_id_d     = vend_id_q;
      did_buy_d     = 1'b0;
      coin_reject_d = 1'b0;
      sel_error_d   = SEL_NONE;
      coin_try      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            coin_try = 1'b1;
         end
         ST_COLLECT: begin
            // cancel > select > coin; a coin losing priority is rejected below.
            if (cancel_i) begin
               state_d = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
            end else if (select_valid_i) begin
               if (!stock_ok_i) begin
                  sel_error_d = SEL_NO_STOCK;
               end else if (credit_q < price_ext) begin
                  sel_error_d = SEL_NO_CREDIT;
               end else begin
                  vend_id_d = product_id_i;
                  credit_d  = credit_q - price_ext;
                  state_d   = ST_DISPENSE;
               end
            end else begin
               coin_try = 1'b1;
               if (!coin_valid_i && tmo_hit) begin
                  state_d = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
               end
            end
         end
         ST_DISPENSE: begin
            if (vend_valid_q && vend_ready_i) begin
               did_buy_d = 1'b1;
               state_d   = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
            end
         end
         ST_CHANGE: begin
            if (change_valid_q && change_ready_i) begin
               credit_d = credit_q - change_val;
               if (credit_d == '0) begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (coin_valid_i) begin
         if (coin_try && coin_ok) begin
            credit_d = credit_q + coin_val;
            state_d  = ST_COLLECT;
         end else begin
            coin_reject_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q        <= ST_IDLE;
         credit_q       <= '0;
         vend_id_q      <= '0;
         vend_valid_q   <= 1'b0;
         did_buy_q      <= 1'b0;
         change_valid_q <= 1'b0;
         change_coin_q  <= COIN_5;
         coin_reject_q  <= 1'b0;
         sel_error_q    <= SEL_NONE;
      end else begin
         state_q        <= state_d;
         credit_q       <= credit_d;
         vend_id_q      <= vend_id_d;
         vend_valid_q   <= (state_d == ST_DISPENSE);
         did_buy_q      <= did_buy_d;
         change_valid_q <= (state_d == ST_CHANGE);
         change_coin_q  <= pick_coin;
         coin_reject_q  <= coin_reject_d;
         sel_error_q    <= sel_error_d;
      end
   end

   assign vend_valid_o   = vend_valid_q;
   assign vend_id_o      = vend_id_q;
   assign did_buy_o      = did_buy_q;
   assign change_valid_o = change_valid_q;
   assign change_coin_o  = change_coin_q;
   assign credit_o       = credit_q;
   assign state_o        = state_q;
   assign coin_reject_o  = coin_reject_q;
   assign sel_error_o    = sel_error_q;

endmodule

// File: tb/tb_vend_sequencer.sv
`timescale 1ns/1ps
module tb_vend_sequencer;

   localparam int TMO = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        coin_valid = 1'b0;
   logic [1:0]  coin = 2'b00;
   logic        select_valid = 1'b0;
   logic [2:0]  product_id = 3'd0;
   logic [7:0]  price = 8'd0;
   logic        stock_ok = 1'b1;
   logic        cancel = 1'b0;
   logic        vend_ready = 1'b0;
   logic        change_ready = 1'b0;
   logic        vend_valid, did_buy, change_valid, coin_reject;
   logic [2:0]  vend_id;
   logic [1:0]  change_coin, state, sel_error;
   logic [15:0] credit;

   always #5 clk = ~clk;

   vend_sequencer #(
      .CREDIT_W       (16),
      .MAX_CREDIT     (200),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clock_i        (clk),
      .reset_i        (rst),
      .coin_valid_i   (coin_valid),
      .coin_i         (coin),
      .select_valid_i (select_valid),
      .product_id_i   (product_id),
      .price_i        (price),
      .stock_ok_i     (stock_ok),
      .cancel_i       (cancel),
      .vend_valid_o   (vend_valid),
      .vend_id_o      (vend_id),
      .vend_ready_i   (vend_ready),
      .did_buy_o      (did_buy),
      .change_valid_o (change_valid),
      .change_coin_o  (change_coin),
      .change_ready_i (change_ready),
      .credit_o       (credit),
      .state_o        (state),
      .coin_reject_o  (coin_reject),
      .sel_error_o    (sel_error)
   );

   int tests = 0;
   int fails = 0;

   // Scoreboard queues filled at stimulus time, drained by the monitor.
   int q_reject[$];   // expected credit shown alongside each coin_reject
   int q_sel[$];      // expected sel_error codes
   int q_vend[$];     // expected product ids at the dispense handshake
   int q_change[$];   // expected change coin codes, in order

   // Reference model: credit, phase (0 idle,1 collect,2 dispense,3 change).
   int m_credit = 0;
   int m_state  = 0;
   int m_idle   = 0;
   int m_list[$];
   bit buy_pend = 1'b0;

   function automatic int val_of(input int code);
      case (code)
         0: return 5;
         1: return 10;
         2: return 20;
         default: return 50;
      endcase
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Refund: the greedy coin sequence for the whole credit.
   task automatic enter_refund();
      int c;
      int code;
      c = m_credit;
      if (c == 0) begin
         m_state = 0;
         return;
      end
      m_state = 3;
      while (c > 0) begin
         code = (c >= 50) ? 3 : (c >= 20) ? 2 : (c >= 10) ? 1 : 0;
         m_list.push_back(code);
         q_change.push_back(code);
         c -= val_of(code);
      end
   endtask

   task automatic model_step(input bit cv, input int cc, input bit sv, input int pid,
                             input int prc, input bit stk, input bit cn,
                             input bit vr, input bit hr);
      bit rej;
      rej = 1'b0;
      case (m_state)
         0: begin
            if (cv) begin
               if (m_credit + val_of(cc) <= 200) begin
                  m_credit += val_of(cc);
                  m_state = 1;
                  m_idle = 0;
               end else begin
                  rej = 1'b1;
               end
            end
         end
         1: begin
            if (cn) begin
               rej = cv;
               enter_refund();
            end else if (sv) begin
               rej = cv;
               if (!stk) q_sel.push_back(1);
               else if (m_credit < prc) q_sel.push_back(2);
               else begin
                  m_credit -= prc;
                  q_vend.push_back(pid);
                  m_state = 2;
               end
            end else if (cv) begin
               if (m_credit + val_of(cc) <= 200) m_credit += val_of(cc);
               else rej = 1'b1;
            end
`ifdef VEND_TIMEOUT_EN
            else begin
               m_idle++;
               if (m_idle >= TMO) enter_refund();
            end
`endif
            if (cv || sv || cn) m_idle = 0;
         end
         2: begin
            rej = cv;
            if (vr) begin
               if (m_credit > 0) enter_refund();
               else m_state = 0;
            end
         end
         default: begin
            rej = cv;
            if (hr) begin
               m_credit -= val_of(m_list.pop_front());
               if (m_credit == 0) m_state = 0;
            end
         end
      endcase
      if (rej) q_reject.push_back(m_credit);
   endtask

   // One clock of stimulus; returns 1 ns after the sampling edge.
   task automatic drive(input bit cv, input int cc, input bit sv, input int pid,
                        input int prc, input bit stk, input bit cn,
                        input bit vr, input bit hr);
      coin_valid   = cv;
      coin         = 2'(cc);
      select_valid = sv;
      product_id   = 3'(pid);
      price        = 8'(prc);
      stock_ok     = stk;
      cancel       = cn;
      vend_ready   = vr;
      change_ready = hr;
      model_step(cv, cc, sv, pid, prc, stk, cn, vr, hr);
      @(posedge clk);
      #1;
      coin_valid   = 1'b0;
      select_valid = 1'b0;
      cancel       = 1'b0;
   endtask

   task automatic put_coin(input int cc);
      drive(1, cc, 0, 0, 0, 1, 0, 0, 0);
      $display("[TB] coin %0d -> credit %0d state %0d", cc, credit, state);
   endtask

   task automatic idle(input bit vr, input bit hr);
      drive(0, 0, 0, 0, 0, 1, 0, vr, hr);
   endtask

   // Run until the model is back in IDLE with random handshake readiness.
   task automatic drain(input string name);
      int guard;
      guard = 0;
      while (m_state != 0 && guard < 400) begin
         if (m_state == 1)
            drive(0, 0, 0, 0, 0, 1, 1, 0, 0);
         else
            drive(($urandom % 5) == 0, $urandom % 4, 0, 0, 0, 1, 0,
                  $urandom % 2, $urandom % 2);
         guard++;
      end
      if (guard >= 400) check({name, "_drain_timeout"}, state, 0);
      check({name, "_end_state"}, state, 0);
      check({name, "_end_credit"}, credit, 0);
      $display("[TB] %s done: state %0d credit %0d", name, state, credit);
   endtask

   // Monitor: compares DUT outputs against the scoreboard queues.
   always @(negedge clk) begin
      if (!rst) begin
         if (coin_reject) begin
            if (q_reject.size() == 0) check("coin_reject_unexpected", coin_reject, 0);
            else check("coin_reject_credit", credit, q_reject.pop_front());
         end
         if (sel_error != 2'b00) begin
            if (q_sel.size() == 0) check("sel_error_unexpected", sel_error, 0);
            else check("sel_error", sel_error, q_sel.pop_front());
         end
         if (did_buy || buy_pend) check("did_buy", did_buy, buy_pend);
         buy_pend = 1'b0;
         if (vend_valid && vend_ready) begin
            if (q_vend.size() == 0) check("vend_unexpected", vend_valid, 0);
            else begin
               int e;
               e = q_vend.pop_front();
               check("vend_id", vend_id, e);
               $display("[TB] vend id %0d (expected %0d)", vend_id, e);
            end
            buy_pend = 1'b1;
         end
         if (change_valid && change_ready) begin
            if (q_change.size() == 0) check("change_unexpected", change_valid, 0);
            else begin
               int e;
               e = q_change.pop_front();
               check("change_coin", change_coin, e);
               $display("[TB] change coin %0d (expected %0d)", change_coin, e);
            end
         end
      end
   end

   initial begin
      int n, r, prc;

      // Reset values
      #12;
      check("rst_state", state, 0);
      check("rst_credit", credit, 0);
      check("rst_vend_valid", vend_valid, 0);
      check("rst_vend_id", vend_id, 0);
      check("rst_change_valid", change_valid, 0);
      check("rst_did_buy", did_buy, 0);
      check("rst_coin_reject", coin_reject, 0);
      check("rst_sel_error", sel_error, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Basic sale with change, price 15
      put_coin(1);
      put_coin(1);
      check("sale_credit20", credit, 20);
      check("sale_collect", state, 1);
      drive(0, 0, 1, 1, 15, 1, 0, 0, 0);
      check("sale_dispense", state, 2);
      check("sale_credit5", credit, 5);
      check("sale_vend_valid", vend_valid, 1);
      check("sale_vend_id", vend_id, 1);
      idle(0, 0);
      check("sale_vend_hold_valid", vend_valid, 1);
      check("sale_vend_hold_id", vend_id, 1);
      idle(1, 0);
      check("sale_did_buy", did_buy, 1);
      check("sale_vend_drop", vend_valid, 0);
      check("sale_change_state", state, 3);
      check("sale_change_coin", change_coin, 0);
      idle(0, 1);
      check("sale_did_buy_once", did_buy, 0);
      check("sale_idle", state, 0);
      check("sale_credit0", credit, 0);
      check("sale_change_drop", change_valid, 0);

      // Insufficient credit, price 45
      put_coin(2);
      drive(0, 0, 1, 2, 45, 1, 0, 0, 0);
      check("insuf_sel_error", sel_error, 2);
      check("insuf_state", state, 1);
      check("insuf_credit", credit, 20);
      put_coin(3);
      check("insuf_credit70", credit, 70);
      drive(0, 0, 1, 2, 45, 1, 0, 0, 0);
      check("insuf_credit25", credit, 25);
      idle(1, 0);
      check("insuf_first_change", change_coin, 2);
      idle(0, 1);
      check("insuf_credit5", credit, 5);
      check("insuf_second_change", change_coin, 0);
      drain("insufficient");

      // Out of stock
      put_coin(1);
      drive(0, 0, 1, 4, 5, 0, 0, 0, 0);
      check("oos_sel_error", sel_error, 1);
      check("oos_credit", credit, 10);
      check("oos_no_vend", vend_valid, 0);
      check("oos_state", state, 1);
      drain("out_of_stock");

      // Overflow and priority
      put_coin(3); put_coin(3); put_coin(3); put_coin(2); put_coin(2);
      check("ovf_credit190", credit, 190);
      put_coin(3);
      check("ovf_reject", coin_reject, 1);
      check("ovf_credit_kept", credit, 190);
      drive(1, 0, 1, 2, 10, 1, 1, 0, 0);
      check("prio_state_change", state, 3);
      check("prio_reject", coin_reject, 1);
      check("prio_no_sel_error", sel_error, 0);
      check("prio_credit", credit, 190);
      drain("overflow_priority");

      // Reset in the middle of CHANGE
      put_coin(1);
      put_coin(2);
      drive(0, 0, 0, 0, 0, 1, 1, 0, 0);
      check("mid_change_state", state, 3);
      check("mid_change_credit", credit, 30);
      #1 rst = 1'b1;
      #1;
      check("async_rst_state", state, 0);
      check("async_rst_credit", credit, 0);
      check("async_rst_change_valid", change_valid, 0);
      #1 rst = 1'b0;
      m_state = 0;
      m_credit = 0;
      m_list.delete();
      q_change.delete();
      $display("[TB] reset mid-change: state %0d credit %0d", state, credit);

      // Inactivity in COLLECT
      put_coin(1);
`ifdef VEND_TIMEOUT_EN
      repeat (TMO - 1) idle(0, 0);
      check("tmo_not_yet", state, 1);
      idle(0, 0);
      check("tmo_state_change", state, 3);
      check("tmo_coin", change_coin, 1);
      check("tmo_credit", credit, 10);
      drain("timeout");
`else
      repeat (100) idle(0, 0);
      check("no_tmo_state", state, 1);
      check("no_tmo_credit", credit, 10);
      drain("no_timeout");
`endif

      // Randomized sessions
      for (int s = 0; s < 60; s++) begin
         n = $urandom_range(1, 6);
         for (int k = 0; k < n; k++) begin
            drive(1, $urandom % 4, 0, 0, 0, 1, 0, $urandom % 2, $urandom % 2);
            check("rnd_coin_credit", credit, m_credit);
         end
         r = $urandom % 10;
         if (r < 2) begin
            drive($urandom % 2, $urandom % 4, $urandom % 2, 0, 0, 1, 1, 0, 0);
         end else begin
            prc = 5 * $urandom_range(0, 40);
            drive($urandom % 2, $urandom % 4, 1, $urandom % 8, prc,
                  ($urandom % 5) != 0, 0, 0, 0);
         end
         check("rnd_action_credit", credit, m_credit);
         check("rnd_action_state", state, m_state);
         $display("[TB] session %0d: credit %0d state %0d", s, credit, state);
         drain("random");
      end

      repeat (3) @(negedge clk);
      #1;
      check("pending_reject", q_reject.size(), 0);
      check("pending_sel", q_sel.size(), 0);
      check("pending_vend", q_vend.size(), 0);
      check("pending_change", q_change.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
